// File: rtl/swi_cond_pkg.sv
// Shared types and default sizing for the SWI input conditioner.
// Optional debouncing is selected with the SWI_COND_DEBOUNCE_EN macro.
package swi_cond_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } db_state_t;

  localparam int SWI_NBITS           = 8;
  localparam int SWI_NSYNC           = 2;
  localparam int SWI_DEBOUNCE_CYCLES = 3;

  // The debounced level is high in both states that sit on the high side.
  function automatic logic db_level(input db_state_t st);
    return (st == ST_HI) || (st == CHK_LO);
  endfunction

endpackage

// File: rtl/swi_debounce_bit.sv
// One switch bit: NSYNC-deep synchroniser, optional debounce FSM and counter
// (SWI_COND_DEBOUNCE_EN), registered level plus one-cycle rise/fall pulses.
module swi_debounce_bit #(
  parameter int NSYNC           = 2,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw_in,
  output logic stable_out,
  output logic rise_out,
  output logic fall_out,
  output logic changed_out
);

  logic [NSYNC-1:0] sync_q, sync_d;
  logic             s;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             changed_q, changed_d;

  always_comb begin
    sync_d = {sync_q[NSYNC-2:0], raw_in};
  end

  assign s = sync_q[NSYNC-1];

`ifdef SWI_COND_DEBOUNCE_EN
  import swi_cond_pkg::*;

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts consecutive synced samples already seen at the candidate level;
  // the sample that brings it to DEBOUNCE_CYCLES commits the new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LO: begin
        cnt_d = '0;
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_HI;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        cnt_d = '0;
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_LO;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stable_d = db_level(state_d);
  end
`else
  // Without debouncing the level simply follows the synchroniser output.
  always_comb begin
    stable_d = s;
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cfg_unused
  end
`endif

  always_comb begin
    rise_d    = stable_d & ~stable_q;
    fall_d    = ~stable_d & stable_q;
    changed_d = rise_d | fall_d;
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      stable_q  <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign stable_out  = stable_q;
  assign rise_out    = rise_q;
  assign fall_out    = fall_q;
  assign changed_out = changed_q;

endmodule

// File: rtl/swi_conditioner.sv
// Conditions the raw SWI bus: per-bit synchronise/debounce plus edge pulses.
// Debouncing is present only when SWI_COND_DEBOUNCE_EN is defined.
module swi_conditioner
  import swi_cond_pkg::*;
#(
  parameter int NBITS           = SWI_NBITS,
  parameter int NSYNC           = SWI_NSYNC,
  parameter int DEBOUNCE_CYCLES = SWI_DEBOUNCE_CYCLES
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_stable,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             changed
);

  logic [NBITS-1:0] bit_changed;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    swi_debounce_bit #(
      .NSYNC           (NSYNC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_2       (clk_2),
      .reset       (reset),
      .raw_in      (swi_raw[i]),
      .stable_out  (swi_stable[i]),
      .rise_out    (rise[i]),
      .fall_out    (fall[i]),
      .changed_out (bit_changed[i])
    );
  end

  // Each per-bit flag is already registered, so the OR adds no path from swi_raw.
  assign changed = |bit_changed;

endmodule

// File: tb/tb_swi_conditioner.sv
// Bench for swi_conditioner: directed vector table, hand-written reset
// sequences and randomized traffic checked against a window-based model.
module tb_swi_conditioner;

  localparam int NBITS = 8;
  localparam int NSYNC = 2;
`ifdef SWI_COND_DEBOUNCE_EN
  localparam int          DC_EFF   = 3;
  localparam logic [7:0]  STEP_BIT = 8'h01;
`else
  localparam int          DC_EFF   = 1;
  localparam logic [7:0]  STEP_BIT = 8'h80;
`endif
  localparam int LAT = NSYNC + DC_EFF;

  logic             clk_2   = 1'b0;
  logic             reset   = 1'b0;
  logic [NBITS-1:0] swi_raw = '0;
  logic [NBITS-1:0] swi_stable;
  logic [NBITS-1:0] rise;
  logic [NBITS-1:0] fall;
  logic             changed;

  swi_conditioner dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .swi_raw    (swi_raw),
    .swi_stable (swi_stable),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed)
  );

  // ---------------- clock ----------------
  always #5 clk_2 = ~clk_2;

  // ---------------- reference model ----------------
  // A new level is accepted once the last DC_EFF synchronised samples all show it.
  logic [24:0] exp_q[$];
  logic [7:0]  pipe_q[$];
  logic [7:0]  win_q[$];
  logic [7:0]  m_stable;
  logic [7:0]  m_sample, m_all1, m_all0, m_next, m_rise, m_fall;

  always @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      pipe_q.delete();
      win_q.delete();
      for (int i = 0; i < NSYNC; i++) pipe_q.push_back(8'h00);
      for (int i = 0; i < DC_EFF; i++) win_q.push_back(8'h00);
      m_stable = 8'h00;
      exp_q.delete();
      exp_q.push_back(25'd0);
    end else begin
      m_sample = pipe_q.pop_front();
      pipe_q.push_back(swi_raw);
      void'(win_q.pop_front());
      win_q.push_back(m_sample);
      m_all1 = 8'hFF;
      m_all0 = 8'hFF;
      foreach (win_q[i]) begin
        m_all1 = m_all1 & win_q[i];
        m_all0 = m_all0 & ~win_q[i];
      end
      m_next = (m_stable | m_all1) & ~m_all0;
      m_rise = m_next & ~m_stable;
      m_fall = m_stable & ~m_next;
      exp_q.push_back({|(m_rise | m_fall), m_fall, m_rise, m_next});
      m_stable = m_next;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [24:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL model_queue: got empty expected 1 entry at t=%0t", $time);
    end else begin
      e = exp_q[$];
      exp_q.delete();
      chk("model_stable", swi_stable, e[7:0]);
      chk("model_rise", rise, e[15:8]);
      chk("model_fall", fall, e[23:16]);
      chk("model_changed", changed, e[24]);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, let one posedge pass, sample at the next negedge.
  task automatic cycle(input logic [7:0] raw);
    swi_raw = raw;
    @(posedge clk_2);
    @(negedge clk_2);
    model_check();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] raw;
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] raw, input logic [7:0] st,
                              input logic [7:0] ri, input logic [7:0] fa);
    vec_t v;
    v.raw     = raw;
    v.stable  = st;
    v.rise    = ri;
    v.fall    = fa;
    v.changed = |(ri | fa);
    tbl.push_back(v);
  endfunction

  // Clean step from a settled level: new level and pulses appear at the LAT-th edge.
  function automatic void add_step(input logic [7:0] from, input logic [7:0] to, input int n);
    for (int c = 1; c <= n; c++) begin
      add(to,
          (c >= LAT) ? to : from,
          (c == LAT) ? (to & ~from) : 8'h00,
          (c == LAT) ? (from & ~to) : 8'h00);
    end
  endfunction

  logic [7:0] cur;
  int         flip_div;

  initial begin
    // reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clk_2);
    chk("reset_stable", swi_stable, 8'h00);
    chk("reset_rise", rise, 8'h00);
    chk("reset_fall", fall, 8'h00);
    chk("reset_changed", changed, 1'b0);
    reset = 1'b0;

    // table-driven directed vectors
    add_step(8'h00, STEP_BIT, LAT + 1);
    add_step(STEP_BIT, 8'h00, LAT + 1);
`ifdef SWI_COND_DEBOUNCE_EN
    add(8'h02, 8'h00, 8'h00, 8'h00);
    add(8'h02, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < LAT + 2; i++) add(8'h00, 8'h00, 8'h00, 8'h00);
    add(8'h08, 8'h00, 8'h00, 8'h00);
    add(8'h00, 8'h00, 8'h00, 8'h00);
    add_step(8'h00, 8'h08, LAT + 1);
    add_step(8'h08, 8'h00, LAT + 1);
`endif
    add_step(8'h00, 8'h0F, LAT + 1);
    add_step(8'h0F, 8'hF0, LAT + 1);
    add_step(8'hF0, 8'h00, LAT + 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].raw);
      chk($sformatf("tbl%0d_stable", i), swi_stable, tbl[i].stable);
      chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), fall, tbl[i].fall);
      chk($sformatf("tbl%0d_changed", i), changed, tbl[i].changed);
    end

    // mid-cycle reset pulse with all switches high
    repeat (LAT + 1) cycle(8'hFF);
    chk("pre_pulse_stable", swi_stable, 8'hFF);
    #1 reset = 1'b1;
    #1;
    chk("pulse_imm_stable", swi_stable, 8'h00);
    chk("pulse_imm_rise", rise, 8'h00);
    chk("pulse_imm_fall", fall, 8'h00);
    chk("pulse_imm_changed", changed, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk_2);
    #1;
    chk("pulse_next_stable", swi_stable, 8'h00);
    chk("pulse_next_rise", rise, 8'h00);
    chk("pulse_next_fall", fall, 8'h00);
    @(negedge clk_2);
    repeat (LAT + 3) cycle(8'h00);
    chk("pulse_drain_stable", swi_stable, 8'h00);

    // reset held across the 4th edge of a rising step, then released
    for (int c = 1; c <= 3; c++) cycle(STEP_BIT);
    reset = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      cycle(STEP_BIT);
      chk("rst_hold_stable", swi_stable, 8'h00);
      chk("rst_hold_rise", rise, 8'h00);
    end
    reset = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      cycle(STEP_BIT);
      chk($sformatf("rel%0d_stable", c), swi_stable, (c >= LAT) ? STEP_BIT : 8'h00);
      chk($sformatf("rel%0d_rise", c), rise, (c == LAT) ? STEP_BIT : 8'h00);
      chk($sformatf("rel%0d_changed", c), changed, (c == LAT) ? 1'b1 : 1'b0);
    end
    repeat (LAT + 1) cycle(8'h00);

    // randomized traffic, mixing bouncy and quiet phases plus stray reset pulses
    cur = 8'h00;
    for (int blk = 0; blk < 40; blk++) begin
      case ($urandom_range(3, 0))
        0:       flip_div = 2;
        1:       flip_div = 4;
        2:       flip_div = 8;
        default: flip_div = 32;
      endcase
      for (int k = 0; k < 50; k++) begin
        for (int b = 0; b < NBITS; b++) begin
          if ($urandom_range(flip_div - 1, 0) == 0) cur[b] = ~cur[b];
        end
        if ($urandom_range(199, 0) == 0) begin
          #1 reset = 1'b1;
          #1 reset = 1'b0;
        end
        cycle(cur);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
